// File: rtl/fetch_buffer.sv
// Instruction fetch queue: fetches sequentially from imem into a DEPTH-entry
// circular buffer of {pc, instr}, presents the head to decode, and flushes on redirect.
module fetch_buffer #(
   parameter int unsigned         DEPTH    = 4,
   parameter int unsigned         ADDR_W   = 32,
   parameter int unsigned         INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter logic [INSTR_W-1:0]  NOP      = 32'h21000000
) (
   input  logic                          clock,
   input  logic                          reset,
   output logic [ADDR_W-1:0]             imem_addr,
   output logic                          imem_req,
   input  logic [INSTR_W-1:0]            imem_instr,
   input  logic                          imem_stall,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INSTR_W-1:0]            out_instr,
   output logic [ADDR_W-1:0]             out_pc,
   input  logic                          redirect,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];

   logic [ADDR_W-1:0]  fetch_pc_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic               pop;
   logic               push;

   // Head outputs come from registered state only; NOP/0 mask an empty queue.
   always_comb begin
      out_valid = (count_q != '0);
      out_instr = NOP;
      out_pc    = '0;
      if (out_valid) begin
         out_instr = instr_mem[rd_ptr_q];
         out_pc    = pc_mem[rd_ptr_q];
      end
   end

   always_comb begin
      pop       = out_valid & out_ready;
      imem_req  = (count_q < FULL) | pop;
      push      = imem_req & ~imem_stall & ~redirect;
      imem_addr = fetch_pc_q;
      count     = count_q;
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
         instr_mem[wr_ptr_q] <= imem_instr;
      end
   end

   // Redirect wins over push, pop and stall: any same-cycle pop is treated as done.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else if (redirect) begin
         fetch_pc_q <= redirect_pc;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         if (push) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue-level model predicts fetched entries,
// a negedge monitor compares every dequeued head and the per-cycle fetch outputs.
module tb_fetch_buffer;

   localparam int          DEPTH    = 4;
   localparam int          ADDR_W   = 32;
   localparam int          INSTR_W  = 32;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h21000000;

   logic              clock;
   logic              reset;
   logic [31:0]       imem_addr;
   logic              imem_req;
   logic [31:0]       imem_instr;
   logic              imem_stall;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [2:0]        count;
   logic              mode;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      sbq[$];
   int          m_count;
   logic [31:0] m_pc;

   fetch_buffer #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
      .RESET_PC(RESET_PC), .NOP(NOP)
   ) dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_instr(imem_instr),
      .imem_stall(imem_stall), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .redirect(redirect),
      .redirect_pc(redirect_pc), .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic md, input logic [31:0] a);
      return md ? ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F) : a;
   endfunction

   // Instruction memory; garbage while stalled so ignored data is detectable.
   assign imem_instr = imem_stall ? 32'hDEADBEEF : word_at(mode, imem_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy and fetch PC from the queue rules; entries go to the scoreboard.
   always @(posedge clock or negedge reset) begin
      bit p_pop, p_req, p_push;
      if (!reset) begin
         m_pc    = RESET_PC;
         m_count = 0;
         sbq.delete();
      end else begin
         p_pop = (m_count != 0) && out_ready;
         p_req = (m_count < DEPTH) || p_pop;
         if (redirect) begin
            sbq.delete();
            m_count = 0;
            m_pc    = redirect_pc;
         end else begin
            p_push = p_req && !imem_stall;
            if (p_pop) m_count--;
            if (p_push) begin
               sbq.push_back('{pc: m_pc, instr: word_at(mode, m_pc)});
               m_pc++;
               m_count++;
            end
         end
      end
   end

   // Monitor: per-cycle fetch side, and scoreboard pop on every accepted head.
   always @(negedge clock) begin
      entry_t e;
      bit     exp_req;
      exp_req = (m_count < DEPTH) || ((m_count != 0) && out_ready);
      check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("imem_req", 64'(imem_req), 64'(exp_req));
      check("count", 64'(count), 64'(m_count));
      check("out_valid", 64'(out_valid), 64'(m_count != 0));
      if (!out_valid) begin
         check("empty_instr", 64'(out_instr), 64'(NOP));
         check("empty_pc", 64'(out_pc), 64'h0);
      end else if (out_ready) begin
         if (sbq.size() == 0) begin
            check("sb_underflow", 64'(sbq.size()), 64'h1);
         end else begin
            e = sbq.pop_front();
            check("head_pc", 64'(out_pc), 64'(e.pc));
            check("head_instr", 64'(out_instr), 64'(e.instr));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'h0);
      check({tag, "_count"}, 64'(count), 64'h0);
      check({tag, "_instr"}, 64'(out_instr), 64'(NOP));
      check({tag, "_pc"}, 64'(out_pc), 64'h0);
      check({tag, "_addr"}, 64'(imem_addr), 64'(RESET_PC));
   endtask

   initial begin
      reset       = 1'b0;
      imem_stall  = 1'b0;
      out_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mode        = 1'b0;
      step(2);
      check_reset_outputs("rst");

      // Streaming: word = addr, head advances one pc per cycle
      reset     = 1'b1;
      out_ready = 1'b1;
      step(12);
      check("stream_pc", 64'(out_pc), 64'd11);
      check("stream_instr", 64'(out_instr), 64'd11);

      // Backpressure saturates the queue
      out_ready = 1'b0;
      reset     = 1'b0;
      #2;
      reset = 1'b1;
      step(10);
      check("full_count", 64'(count), 64'd4);
      check("full_req", 64'(imem_req), 64'h0);
      check("full_addr", 64'(imem_addr), 64'd4);
      check("full_head", 64'(out_pc), 64'h0);

      // Full queue dequeues and refetches in the same cycle
      out_ready = 1'b1;
      #1;
      check("full_pop_req", 64'(imem_req), 64'h1);
      step(1);
      check("full_pop_count", 64'(count), 64'd4);
      check("full_pop_head", 64'(out_pc), 64'd1);

      // Stall at addr 5 while draining
      imem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("stall_addr", 64'(imem_addr), 64'd5);
      end
      imem_stall = 1'b0;
      step(1);
      check("stall_release_addr", 64'(imem_addr), 64'd6);
      check("stall_release_count", 64'(count), 64'd1);
      check("stall_release_head", 64'(out_pc), 64'd5);

      // Redirect with three entries queued
      out_ready = 1'b0;
      reset     = 1'b0;
      #2;
      reset = 1'b1;
      step(3);
      check("pre_redirect_count", 64'(count), 64'd3);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step(1);
      redirect = 1'b0;
      check("redirect_count", 64'(count), 64'h0);
      check("redirect_instr", 64'(out_instr), 64'(NOP));
      check("redirect_addr", 64'(imem_addr), 64'h100);
      step(1);
      check("redirect_head", 64'(out_pc), 64'h100);

      // Async reset mid-stream while stalled and redirecting
      step(1);
      check("pre_reset_count", 64'(count), 64'd2);
      imem_stall  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      reset       = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      step(1);
      reset      = 1'b1;
      imem_stall = 1'b0;
      redirect   = 1'b0;
      step(1);
      check("post_reset_count", 64'(count), 64'd1);
      check("post_reset_head", 64'(out_pc), 64'(RESET_PC));

      // Randomized traffic with hashed memory contents
      mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         imem_stall  = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         step(1);
      end
      redirect   = 1'b0;
      imem_stall = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of queue entries, power of two, minimum 2.
REQ-002 SHALL provide parameter ADDR_W, default 32, program-counter width, word-addressed.
REQ-003 SHALL provide parameter INSTR_W, default 32, instruction width.
REQ-004 SHALL provide parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL provide parameter NOP, default 32'h21000000, instruction presented while the queue is empty.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-008 SHALL have port imem_addr, output, ADDR_W bits: fetch address, equal to the internal fetch PC.
REQ-009 SHALL have port imem_req, output, 1 bit: fetch request this cycle.
REQ-010 SHALL have port imem_instr, input, INSTR_W bits: instruction at imem_addr, valid in the same cycle unless imem_stall is high.
REQ-011 SHALL have port imem_stall, input, 1 bit: memory not ready; imem_instr is ignored this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: queue head is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-014 SHALL have port out_instr, output, INSTR_W bits: head instruction.
REQ-015 SHALL have port out_pc, output, ADDR_W bits: head instruction address.
REQ-016 SHALL have port redirect, input, 1 bit: branch taken; flush the queue.
REQ-017 SHALL have port redirect_pc, input, ADDR_W bits: new fetch address when redirect is high.
REQ-018 SHALL have port count, output, clog2(DEPTH+1) bits: current occupancy.

Function
REQ-019 SHALL hold a circular queue of {pc, instr} entries with read and write pointers that wrap modulo DEPTH.
REQ-020 SHALL define pop = out_valid & out_ready, and push = imem_req & ~imem_stall & ~redirect.
REQ-021 SHALL drive imem_req = (count < DEPTH) | pop, so a full queue refetches in the same cycle as a dequeue.
REQ-022 SHALL, on push, write {fetch PC, imem_instr} at the write pointer and advance the fetch PC by 1 (modulo 2^ADDR_W).
REQ-023 SHALL hold the fetch PC and the write pointer when imem_req is low or imem_stall is high, and SHALL NOT advance imem_addr.
REQ-024 SHALL give a fetch-to-output latency of exactly one cycle: a word pushed in cycle t is visible at the head in cycle t+1 when the queue was empty.
REQ-025 SHALL drive out_valid = (count != 0), combinationally from registered state only.
REQ-026 SHALL drive out_instr = NOP and out_pc = 0 when count == 0.
REQ-027 SHALL apply push and pop in the same cycle with count unchanged, including when the queue is full.
REQ-028 SHALL, when redirect is high: set count and both pointers to 0 at the next edge, load the fetch PC with redirect_pc, and discard any imem_instr arriving in that cycle.
REQ-029 SHALL treat a pop in a redirect cycle as completed; the consumer discards that instruction.
REQ-030 SHALL give redirect priority over push, pop and imem_stall.
REQ-031 SHALL present the first redirect-target fetch on imem_addr in the cycle after redirect.
REQ-032 SHALL keep count within 0..DEPTH at all times; no push is performed when full without a pop.
REQ-033 SHALL keep out_instr and out_pc stable while out_valid is high and out_ready is low.

Reset
REQ-034 SHALL, while reset is low, asynchronously force: fetch PC = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_instr = NOP, out_pc = 0.
REQ-035 SHALL fetch from RESET_PC in the first cycle after reset rises.
REQ-036 SHALL, when reset is asserted mid-stall or mid-redirect, discard all in-flight state with no residual push.

Verification
REQ-037 SHALL pass: reset release, imem returns word = addr, out_ready = 1 -> out_pc sequence 0,1,2,... one per cycle from the second cycle, out_instr = out_pc.
REQ-038 SHALL pass: out_ready = 0 for 10 cycles, DEPTH = 4 -> count saturates at 4, imem_req = 0, imem_addr holds 4, head stays pc 0.
REQ-039 SHALL pass: queue full, then out_ready = 1 -> imem_req = 1 in the same cycle, count stays 4, no entry lost or duplicated.
REQ-040 SHALL pass: imem_stall high for 3 cycles at addr 5 -> imem_addr holds 5, no push, then the word at 5 is enqueued exactly once.
REQ-041 SHALL pass: count = 3 and redirect with redirect_pc = 0x100 while imem_stall = 0 -> next cycle count = 0, out_instr = NOP, imem_addr = 0x100, and the head one cycle later has pc 0x100.
REQ-042 SHALL pass: reset pulsed low mid-stream with count = 2 -> outputs return to reset values immediately, without a clock edge.
